// File: rtl/nbody_pkg.sv
// nbody_pkg: shared definitions for the N-body pair scheduling path.
//   N_MAX   - maximum number of bodies held in the position RAM
//   CW      - signed coordinate width
//   IDX_W   - body index width
//   coord_t - signed coordinate type at the default width
//   state_e - scheduler FSM states
package nbody_pkg;

  localparam int N_MAX = 16;
  localparam int CW    = 16;
  localparam int IDX_W = $clog2(N_MAX);

  typedef logic signed [CW-1:0] coord_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_I  = 3'd1,
    ST_CAP_I = 3'd2,
    ST_RD_J  = 3'd3,
    ST_CAP_J = 3'd4,
    ST_OUT   = 3'd5
  } state_e;

endpackage

// File: rtl/pe_pair_scheduler_index_gen.sv
// pair_index_gen: i/j body counters for the ordered pair sweep.
//   clk_i, rst_i   - clock, async active-high reset
//   n_i            - body count of the current frame
//   frame_init_i   - restart at i = 0
//   row_init_i     - load first j of the row (skips i)
//   j_adv_i        - step j to the next index, skipping i
//   i_adv_i        - step to the next row
//   idx_i_o/j_o    - current indices
//   j_first_o      - first j of the current row
//   j_next_o       - next j after skipping i
//   i_next_o       - i + 1
//   row_last_o     - current j is the last of the row
//   i_last_o       - current i is the last row
//   frame_last_o   - current pair is the last of the frame
module pair_index_gen #(
  parameter int IDX_W = nbody_pkg::IDX_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W:0]   n_i,
  input  logic             frame_init_i,
  input  logic             row_init_i,
  input  logic             j_adv_i,
  input  logic             i_adv_i,
  output logic [IDX_W-1:0] idx_i_o,
  output logic [IDX_W-1:0] idx_j_o,
  output logic [IDX_W-1:0] j_first_o,
  output logic [IDX_W-1:0] j_next_o,
  output logic [IDX_W-1:0] i_next_o,
  output logic             row_last_o,
  output logic             i_last_o,
  output logic             frame_last_o
);

  logic [IDX_W-1:0] i_q;
  logic [IDX_W-1:0] j_q;
  logic [IDX_W:0]   j_inc_s;
  logic [IDX_W:0]   j_nxt_s;

  // Next-j decode: one extra bit so a j that runs off the row compares against n.
  always_comb begin
    j_inc_s = {1'b0, j_q} + (IDX_W+1)'(1);
    if (j_inc_s == {1'b0, i_q}) begin
      j_nxt_s = j_inc_s + (IDX_W+1)'(1);
    end else begin
      j_nxt_s = j_inc_s;
    end
    if (i_q == {IDX_W{1'b0}}) begin
      j_first_o = (IDX_W)'(1);
    end else begin
      j_first_o = {IDX_W{1'b0}};
    end
    row_last_o   = (j_nxt_s >= n_i);
    i_last_o     = ({1'b0, i_q} == (n_i - (IDX_W+1)'(1)));
    frame_last_o = row_last_o && i_last_o;
    j_next_o     = j_nxt_s[IDX_W-1:0];
    i_next_o     = i_q + (IDX_W)'(1);
  end

  // Index counters; control strobes come from mutually exclusive FSM states.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      i_q <= {IDX_W{1'b0}};
      j_q <= {IDX_W{1'b0}};
    end else if (frame_init_i) begin
      i_q <= {IDX_W{1'b0}};
      j_q <= {IDX_W{1'b0}};
    end else if (row_init_i) begin
      j_q <= j_first_o;
    end else if (j_adv_i) begin
      j_q <= j_next_o;
    end else if (i_adv_i) begin
      i_q <= i_next_o;
    end else begin
      i_q <= i_q;
      j_q <= j_q;
    end
  end

  assign idx_i_o = i_q;
  assign idx_j_o = j_q;

endmodule

// File: rtl/pe_pair_scheduler.sv
// pe_pair_scheduler: streams every ordered pair (i, j), i != j, of the body
// position RAM to the pairwise PE under a valid/ready handshake.
//   clk, rst              - clock, async active-high reset
//   start, n_cfg          - frame start and body count (clamped to N_MAX)
//   busy, done            - frame in progress / one-cycle end-of-frame pulse
//   rd_en, rd_addr        - position RAM read port (data one cycle later)
//   rd_data               - {y, x} returned by the RAM
//   pair_valid/ready      - handshake towards the PE
//   x_i, y_i, x_j, y_j    - coordinates of the presented pair
//   idx_i, idx_j          - indices of the presented pair
//   row_last, frame_last  - end-of-row / end-of-frame markers (valid-qualified)
module pe_pair_scheduler #(
  parameter int N_MAX = nbody_pkg::N_MAX,
  parameter int CW    = nbody_pkg::CW,
  parameter int IDX_W = $clog2(N_MAX)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IDX_W:0]       n_cfg,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [IDX_W-1:0]     rd_addr,
  input  logic [2*CW-1:0]      rd_data,
  output logic                 pair_valid,
  input  logic                 pair_ready,
  output logic signed [CW-1:0] x_i,
  output logic signed [CW-1:0] y_i,
  output logic signed [CW-1:0] x_j,
  output logic signed [CW-1:0] y_j,
  output logic [IDX_W-1:0]     idx_i,
  output logic [IDX_W-1:0]     idx_j,
  output logic                 row_last,
  output logic                 frame_last
);

  import nbody_pkg::*;

  state_e              state_q;
  logic [IDX_W:0]      n_q;
  logic [IDX_W:0]      n_clamped_s;
  logic                start_ok_s;
  logic                busy_q, done_q, rd_en_q, pair_valid_q;
  logic [IDX_W-1:0]    rd_addr_q;
  logic signed [CW-1:0] x_i_q, y_i_q, x_j_q, y_j_q;
  logic                frame_init_s, row_init_s, j_adv_s, i_adv_s;
  logic [IDX_W-1:0]    j_first_s, j_next_s, i_next_s;
  logic                row_last_s, i_last_s, frame_last_s;

  // Clamp the requested body count and decode the counter strobes.
  always_comb begin
    if (n_cfg > (IDX_W+1)'(N_MAX)) begin
      n_clamped_s = (IDX_W+1)'(N_MAX);
    end else begin
      n_clamped_s = n_cfg;
    end
    start_ok_s   = (state_q == ST_IDLE) && start && (n_clamped_s >= (IDX_W+1)'(2));
    frame_init_s = start_ok_s;
    row_init_s   = (state_q == ST_CAP_I);
    j_adv_s      = (state_q == ST_OUT) && pair_ready && !row_last_s;
    i_adv_s      = (state_q == ST_OUT) && pair_ready && row_last_s && !i_last_s;
  end

  pair_index_gen #(.IDX_W(IDX_W)) u_index_gen (
    .clk_i        (clk),
    .rst_i        (rst),
    .n_i          (n_q),
    .frame_init_i (frame_init_s),
    .row_init_i   (row_init_s),
    .j_adv_i      (j_adv_s),
    .i_adv_i      (i_adv_s),
    .idx_i_o      (idx_i),
    .idx_j_o      (idx_j),
    .j_first_o    (j_first_s),
    .j_next_o     (j_next_s),
    .i_next_o     (i_next_s),
    .row_last_o   (row_last_s),
    .i_last_o     (i_last_s),
    .frame_last_o (frame_last_s)
  );

  // Scheduler FSM; rd_addr is loaded one state early so the read issues on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      pair_valid_q <= 1'b0;
      x_i_q        <= '0;
      y_i_q        <= '0;
      x_j_q        <= '0;
      y_j_q        <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_ok_s) begin
            n_q       <= n_clamped_s;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            state_q   <= ST_RD_I;
          end else if (start) begin
            // Fewer than two bodies: nothing to pair, finish immediately.
            done_q <= 1'b1;
          end
        end
        ST_RD_I: begin
          rd_en_q <= 1'b0;
          state_q <= ST_CAP_I;
        end
        ST_CAP_I: begin
          x_i_q     <= $signed(rd_data[CW-1:0]);
          y_i_q     <= $signed(rd_data[2*CW-1:CW]);
          rd_en_q   <= 1'b1;
          rd_addr_q <= j_first_s;
          state_q   <= ST_RD_J;
        end
        ST_RD_J: begin
          rd_en_q <= 1'b0;
          state_q <= ST_CAP_J;
        end
        ST_CAP_J: begin
          x_j_q        <= $signed(rd_data[CW-1:0]);
          y_j_q        <= $signed(rd_data[2*CW-1:CW]);
          pair_valid_q <= 1'b1;
          state_q      <= ST_OUT;
        end
        ST_OUT: begin
          if (pair_ready) begin
            pair_valid_q <= 1'b0;
            if (!row_last_s) begin
              rd_en_q   <= 1'b1;
              rd_addr_q <= j_next_s;
              state_q   <= ST_RD_J;
            end else if (!i_last_s) begin
              rd_en_q   <= 1'b1;
              rd_addr_q <= i_next_s;
              state_q   <= ST_RD_I;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          busy_q       <= 1'b0;
          rd_en_q      <= 1'b0;
          pair_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign pair_valid = pair_valid_q;
  assign x_i        = x_i_q;
  assign y_i        = y_i_q;
  assign x_j        = x_j_q;
  assign y_j        = y_j_q;
  assign row_last   = pair_valid_q && row_last_s;
  assign frame_last = pair_valid_q && frame_last_s;

endmodule

// File: tb/tb_pe_pair_scheduler.sv
// tb_pe_pair_scheduler: randomized scoreboard bench for pe_pair_scheduler.
module tb_pe_pair_scheduler;

  localparam int N_MAX = 16;
  localparam int CW    = 16;
  localparam int IDX_W = 4;
  localparam int SNAP_W = 2*IDX_W + 4*CW + 2;

  logic clk = 1'b0;
  logic rst, start, pair_ready;
  logic [IDX_W:0] n_cfg;
  logic busy, done, rd_en, pair_valid, row_last, frame_last;
  logic [IDX_W-1:0] rd_addr, idx_i, idx_j;
  logic [2*CW-1:0] rd_data;
  logic signed [CW-1:0] x_i, y_i, x_j, y_j;

  always #5 clk = ~clk;

  pe_pair_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .n_cfg(n_cfg),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .pair_valid(pair_valid), .pair_ready(pair_ready),
    .x_i(x_i), .y_i(y_i), .x_j(x_j), .y_j(y_j),
    .idx_i(idx_i), .idx_j(idx_j), .row_last(row_last), .frame_last(frame_last)
  );

  // Position RAM model with one cycle of read latency.
  logic [2*CW-1:0] mem [N_MAX];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  typedef struct {
    logic [IDX_W-1:0]     i, j;
    logic signed [CW-1:0] xi, yi, xj, yj;
    logic                 rl, fl;
  } pair_t;

  pair_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int ready_mode = 0;   // 0: always ready, 1: random stalls, 2: stall on pair (1,2)
  int hs_count = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  // Reference: row-major sweep, j ascending, self skipped; last j of a row is
  // n-1 except on the final row where it is n-2.
  task automatic push_frame(input int n);
    pair_t p;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        if (j != i) begin
          p.i  = IDX_W'(i);
          p.j  = IDX_W'(j);
          p.xi = mem[i][CW-1:0];
          p.yi = mem[i][2*CW-1:CW];
          p.xj = mem[j][CW-1:0];
          p.yj = mem[j][2*CW-1:CW];
          p.rl = (j == ((i == n-1) ? n-2 : n-1));
          p.fl = p.rl && (i == n-1);
          exp_q.push_back(p);
        end
      end
    end
  endtask

  // Ready driver + monitor: picks pair_ready for the coming edge, checks holds
  // under backpressure and pops the scoreboard on every handshake.
  initial begin
    int low_left;
    bit prev_wait;
    logic [SNAP_W-1:0] snap, cur;
    pair_t e;
    low_left = 0; prev_wait = 1'b0; snap = '0; pair_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_wait = 1'b0;
      end else begin
        if (ready_mode == 1) begin
          if (low_left > 0) begin
            pair_ready = 1'b0;
            low_left--;
          end else begin
            pair_ready = 1'b1;
            if ($urandom_range(0, 2) == 0) low_left = $urandom_range(0, 5);
          end
        end else if (ready_mode == 2 && pair_valid && idx_i == 4'd1 && idx_j == 4'd2) begin
          pair_ready = 1'b0;
        end else begin
          pair_ready = 1'b1;
        end
        cur = {idx_i, idx_j, x_i, y_i, x_j, y_j, row_last, frame_last};
        if (prev_wait) begin
          checks++;
          if (pair_valid !== 1'b1 || cur !== snap) begin
            errors++;
            $display("FAIL hold_stable: got valid=%0b out=%h required valid=1 out=%h", pair_valid, cur, snap);
          end
        end
        if (pair_valid && pair_ready) begin
          hs_count++;
          prev_wait = 1'b0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pair: got (%0d,%0d) required none", idx_i, idx_j);
          end else begin
            e = exp_q.pop_front();
            if (idx_i !== e.i || idx_j !== e.j || x_i !== e.xi || y_i !== e.yi ||
                x_j !== e.xj || y_j !== e.yj || row_last !== e.rl || frame_last !== e.fl) begin
              errors++;
              $display("FAIL pair: got (%0d,%0d) xi=%0d yi=%0d xj=%0d yj=%0d rl=%0b fl=%0b required (%0d,%0d) xi=%0d yi=%0d xj=%0d yj=%0d rl=%0b fl=%0b",
                       idx_i, idx_j, x_i, y_i, x_j, y_j, row_last, frame_last,
                       e.i, e.j, e.xi, e.yi, e.xj, e.yj, e.rl, e.fl);
            end
          end
        end else begin
          prev_wait = pair_valid;
          snap = cur;
        end
      end
    end
  end

  // Runs one frame; optionally pokes start/n_cfg mid-frame.
  task automatic run_frame(input int ncfg, input int mode, input bit mid);
    int n, c, first_v, hs0, exp_done;
    bit seen_done, active;
    n = (ncfg > N_MAX) ? N_MAX : ncfg;
    if (n >= 2) push_frame(n);
    exp_done = (n >= 2) ? n*(3*n-1) + 1 : 1;
    hs0 = hs_count;
    ready_mode = mode;
    @(negedge clk);
    start = 1'b1;
    n_cfg = (IDX_W+1)'(ncfg);
    @(negedge clk);
    start = 1'b0;
    c = 1; first_v = 0; seen_done = 1'b0; active = 1'b0;
    while (!seen_done && c <= 20000) begin
      if (busy || rd_en || pair_valid) active = 1'b1;
      if (pair_valid && first_v == 0) first_v = c;
      if (c == 1 && n >= 2) chk("busy_cycle1", busy, 1);
      if (mid && c == 10) begin start = 1'b1; n_cfg = 5'd7; end
      if (mid && c == 12) start = 1'b0;
      if (done) begin
        seen_done = 1'b1;
        chk("busy_in_done", busy, 0);
        if (mode != 1) chk("done_cycle", c, exp_done);
      end else begin
        @(negedge clk);
        c++;
      end
    end
    chk("done_seen", seen_done, 1);
    if (n >= 2) begin
      chk("first_valid_cycle", first_v, 5);
      chk("pair_count", hs_count - hs0, n*(n-1));
      chk("pairs_left", exp_q.size(), 0);
    end else begin
      chk("idle_no_activity", active, 0);
    end
    @(negedge clk);
    chk("done_pulse_width", done, 0);
    ready_mode = 0;
  endtask

  // Aborts a frame with reset while pair (1,2) is waiting, then restarts.
  task automatic reset_test();
    int c;
    bit found;
    push_frame(4);
    ready_mode = 2;
    @(negedge clk);
    start = 1'b1;
    n_cfg = 5'd4;
    @(negedge clk);
    start = 1'b0;
    c = 1; found = 1'b0;
    while (!found && c < 200) begin
      if (pair_valid && idx_i == 4'd1 && idx_j == 4'd2) found = 1'b1;
      else begin @(negedge clk); c++; end
    end
    chk("reach_pair_1_2", found, 1);
    #1 rst = 1'b1;
    #1;
    chk("reset_mid_frame_outputs",
        {busy, done, rd_en, pair_valid, row_last, frame_last, rd_addr, idx_i, idx_j, x_i, y_i, x_j, y_j}, 0);
    exp_q.delete();
    ready_mode = 0;
    repeat (2) begin
      @(negedge clk);
      chk("no_done_in_reset", done, 0);
    end
    #1 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("no_done_after_abort", {done, busy}, 0);
    end
    run_frame(3, 0, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; n_cfg = '0; rd_data = '0;
    for (int k = 0; k < N_MAX; k++) mem[k] = {CW'(-k), CW'(10*k)};
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {busy, done, rd_en, pair_valid, row_last, frame_last, rd_addr, idx_i, idx_j, x_i, y_i, x_j, y_j}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_frame(4, 0, 1'b0);     // done in cycle 45
    run_frame(2, 0, 1'b0);     // done in cycle 11
    run_frame(0, 0, 1'b0);     // done in cycle 1, no activity
    run_frame(1, 0, 1'b0);
    for (int k = 0; k < N_MAX; k++) mem[k] = $urandom();
    run_frame(5, 1, 1'b0);     // random backpressure
    run_frame(5, 1, 1'b0);
    run_frame(4, 0, 1'b1);     // mid-frame start/n_cfg poke ignored
    run_frame(20, 0, 1'b0);    // clamps to 16
    reset_test();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
